// File: rtl/spi_pkg.sv
// Shared types and pad offsets for the SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DESEL,
    SETUP,
    SHIFT,
    HOLD
  } state_e;

  localparam int SCLK_OFS = 0;
  localparam int MOSI_OFS = 1;
  localparam int MISO_OFS = 2;
  localparam int CS_OFS   = 3;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator; the counter restarts on command acceptance.
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_io.sv
// SPI master driving user-area pads: configurable width, mode,
// divider, chip-selects, bit order and CS-held chaining.
module spi_master_io
  import spi_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int N_CS         = 2,
  parameter int DIV_W        = 8,
  parameter int IO_BASE      = 8,
  parameter int MPRJ_IO_PADS = 38,
  localparam int CSW         = $clog2(N_CS) + 1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DATA_W-1:0]       cmd_data,
  input  logic [CSW-1:0]          cmd_cs,
  input  logic                    cmd_hold,
  input  logic                    cfg_cpol,
  input  logic                    cfg_cpha,
  input  logic                    cfg_lsb_first,
  input  logic [DIV_W-1:0]        cfg_div,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    busy,
  input  logic [MPRJ_IO_PADS-1:0] io_in,
  output logic [MPRJ_IO_PADS-1:0] io_out,
  output logic [MPRJ_IO_PADS-1:0] io_oeb
);

  localparam int HCW = $clog2(2 * DATA_W);
  localparam logic [HCW-1:0] LAST = HCW'(2 * DATA_W - 1);

  state_e            state_q, state_d;
  logic [CSW-1:0]    cs_idx_q, cs_idx_d;
  logic              cs_held_q, cs_held_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;
  logic              hold_q, hold_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic              sclk_q, sclk_d;
  logic [HCW-1:0]    hcnt_q, hcnt_d;
  logic              pad_q, pad_d;

  logic              tick, restart, accept;
  logic              lead, smp, shf, miso;
  logic              cs_on, mosi_on;
  logic [DATA_W-1:0] cmd_rev, rx_rev;
  logic              unused_io;

  spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .restart_i (restart),
    .div_i     (div_q),
    .tick_o    (tick)
  );

  assign miso      = io_in[IO_BASE+MISO_OFS];
  assign unused_io = ^io_in;
  assign cmd_ready = (state_q == IDLE) && !wb_rst_i;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = ((state_q != IDLE) || cs_held_q) && !wb_rst_i;
  assign rsp_valid = (state_q == HOLD) && tick && !wb_rst_i;
  assign rsp_data  = wb_rst_i ? '0 : (lsb_q ? rx_rev : rx_q);

  // Even half-period indices end on a leading SCLK edge.
  assign lead = ~hcnt_q[0];
  assign smp  = lead ^ cpha_q;
  assign shf  = cpha_q ? (lead && (hcnt_q[HCW-1:1] != '0)) : ~lead;

  assign cs_on   = (state_q inside {SETUP, SHIFT, HOLD}) ||
                   ((state_q == IDLE) && cs_held_q);
  assign mosi_on = state_q inside {SETUP, SHIFT, HOLD};

  always_comb begin
    cmd_rev = '0;
    rx_rev  = '0;
    for (int i = 0; i < DATA_W; i++) begin
      cmd_rev[i] = cmd_data[DATA_W-1-i];
      rx_rev[i]  = rx_q[DATA_W-1-i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cs_idx_d  = cs_idx_q;
    cs_held_d = cs_held_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    hold_d    = hold_q;
    div_d     = div_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    sclk_d    = sclk_q;
    hcnt_d    = hcnt_q;
    pad_d     = pad_q;
    restart   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          restart   = 1'b1;
          cs_idx_d  = cmd_cs;
          cs_held_d = 1'b0;
          cpol_d    = cfg_cpol;
          cpha_d    = cfg_cpha;
          lsb_d     = cfg_lsb_first;
          hold_d    = cmd_hold;
          div_d     = cfg_div;
          tx_d      = cfg_lsb_first ? cmd_rev : cmd_data;
          rx_d      = '0;
          sclk_d    = cfg_cpol;
          hcnt_d    = '0;
          pad_d     = 1'b0;
          if (cs_held_q && (cs_idx_q != cmd_cs)) begin
            state_d = DESEL;
          end else if (cs_held_q) begin
            // CS already low: burn the setup half-period inside SHIFT.
            state_d = SHIFT;
            pad_d   = 1'b1;
          end else begin
            state_d = SETUP;
          end
        end
      end
      DESEL: if (tick) state_d = SETUP;
      SETUP: if (tick) state_d = SHIFT;
      SHIFT: begin
        if (tick) begin
          if (pad_q) begin
            pad_d = 1'b0;
          end else begin
            sclk_d = ~sclk_q;
            hcnt_d = hcnt_q + 1'b1;
            if (smp) rx_d = {rx_q[DATA_W-2:0], miso};
            if (shf) tx_d = {tx_q[DATA_W-2:0], 1'b0};
            if (hcnt_q == LAST) state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d   = IDLE;
          cs_held_d = hold_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      cs_idx_q  <= '0;
      cs_held_q <= 1'b0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      hold_q    <= 1'b0;
      div_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      sclk_q    <= 1'b0;
      hcnt_q    <= '0;
      pad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cs_idx_q  <= cs_idx_d;
      cs_held_q <= cs_held_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      hold_q    <= hold_d;
      div_q     <= div_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      sclk_q    <= sclk_d;
      hcnt_q    <= hcnt_d;
      pad_q     <= pad_d;
    end
  end

  always_comb begin
    io_out = '0;
    io_oeb = '1;
    io_out[IO_BASE+SCLK_OFS] = sclk_q & ~wb_rst_i;
    io_out[IO_BASE+MOSI_OFS] = mosi_on & tx_q[DATA_W-1] & ~wb_rst_i;
    io_oeb[IO_BASE+SCLK_OFS] = 1'b0;
    io_oeb[IO_BASE+MOSI_OFS] = 1'b0;
    for (int k = 0; k < N_CS; k++) begin
      io_out[IO_BASE+CS_OFS+k] = wb_rst_i | ~(cs_on && (cs_idx_q == CSW'(k)));
      io_oeb[IO_BASE+CS_OFS+k] = 1'b0;
    end
  end

endmodule

// File: doc/spi_master_io.md
Name: spi_master_io

Overview:
- Parametrised SPI master that drives user-area IO pads directly; successor to the fixed single-mode spi_wrapper.
- Adds configurable word width, per-transfer CPOL/CPHA mode, programmable SCLK divider, multiple chip selects, LSB/MSB-first order and chained (CS-held) transfers.
- Instantiated in user_project_wrapper on wb_clk_i/wb_rst_i.
- Commands arrive on a valid/ready interface; received words return on a response strobe.

Parameters:
- DATA_W, 8, bits per transfer word (2..32).
- N_CS, 2, number of chip-select outputs (1..8).
- DIV_W, 8, width of the cfg_div half-period divider.
- IO_BASE, 8, first pad index used. Requirement: IO_BASE+3+N_CS <= MPRJ_IO_PADS.
- MPRJ_IO_PADS, 38, total pad count.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&&ready.
- cmd_data  in  DATA_W  word to transmit.
- cmd_cs  in  $clog2(N_CS)+1  chip-select index.
- cmd_hold  in  1  keep CS asserted after this word (chain).
- cfg_cpol  in  1  SCLK idle level.
- cfg_cpha  in  1  sample phase.
- cfg_lsb_first  in  1  bit order.
- cfg_div  in  DIV_W  half-period = cfg_div+1 clocks.
- rsp_valid  out  1  one-cycle strobe, word received.
- rsp_data  out  DATA_W  received word, valid with rsp_valid.
- busy  out  1  high while not IDLE or while CS is held.
- io_in  in  MPRJ_IO_PADS  pad inputs; MISO at IO_BASE+2.
- io_out  out  MPRJ_IO_PADS  pad outputs: SCLK at IO_BASE+0, MOSI at IO_BASE+1, CS_n[k] at IO_BASE+3+k.
- io_oeb  out  MPRJ_IO_PADS  0 on SCLK/MOSI/CS pads, 1 on all other pads.

Behaviour:
- Reset values: all CS_n=1, SCLK=0, MOSI=0, rsp_valid=0, rsp_data=0, busy=0, cmd_ready=0 during reset and 1 in the first cycle after reset. Unused io_out bits are always 0.
- Reset mid-transfer: state returns to IDLE next cycle, CS released immediately, no rsp_valid.
- cfg_* and cmd_* are latched on acceptance. Changes mid-transfer are ignored.
- cmd_ready=1 only in IDLE.
- Divider tick: one pulse every cfg_div+1 clocks; counter restarts on acceptance.
- States:
  - IDLE: on accept -> SETUP. If CS is held from a previous word with a different cmd_cs -> DESEL first.
  - DESEL: old CS_n=1 for one half-period -> SETUP.
  - SETUP: assert CS_n[cmd_cs]=0, SCLK=cpol, MOSI=first bit. One half-period -> SHIFT. If CS is already held for the same index, SETUP is skipped (go straight to SHIFT).
  - SHIFT: 2*DATA_W half-periods; SCLK toggles on each tick.
    - CPHA=0: sample MISO on leading edges; shift MOSI on trailing edges.
    - CPHA=1: shift on leading edges; sample on trailing edges.
  - HOLD: one half-period with SCLK=cpol. rsp_valid pulses at the end of HOLD.
    - cmd_hold=1: -> IDLE with CS still low.
    - cmd_hold=0: CS_n=1, -> IDLE.
- Latency: rsp_valid asserts (2*DATA_W+2)*(cfg_div+1) cycles after the accept cycle; SETUP is counted even when skipped, so chained words have identical timing.
- Bit order: MSB first unless cfg_lsb_first. rsp_data uses the same order convention as cmd_data.
- Out-of-range cmd_cs (>= N_CS): no CS asserted; the transfer still clocks and returns a response.

Decomposition:
- Package spi_pkg: state enum (IDLE, DESEL, SETUP, SHIFT, HOLD); pad offset constants (SCLK_OFS=0, MOSI_OFS=1, MISO_OFS=2, CS_OFS=3).
- Sub-module spi_clk_gen: divider counter plus half-period tick generator with restart input.

Test Plan:
1. DATA_W=8, div=0, mode0, cmd_data=0xA5, MISO looped to MOSI, cs=0 -> pad IO_BASE+3 low for the whole transfer; 8 SCLK rising edges; rsp_valid exactly 18 cycles after accept; rsp_data=0xA5; CS high afterwards.
2. Mode 3 (cpol=1, cpha=1), div=3, MISO driven by a slave model returning 0x3C -> SCLK idles high; half-period is 4 clocks; rsp_data=0x3C; rsp_valid 72 cycles after accept.
3. Chain: word 0x12 with hold=1 on cs=1, then 0x34 with hold=0 on cs=1 -> CS_n[1] stays low between words; two responses; CS rises only after the second word.
4. Chain with CS change: hold=1 on cs=0, then next command on cs=1 -> CS_n[0] high for exactly div+1 cycles before CS_n[1] falls.
5. lsb_first=1, data=0x01 -> MOSI is high during the first bit period only.
6. wb_rst_i asserted mid-SHIFT -> next cycle: all CS high, SCLK=0, no rsp_valid; cmd_ready=1 the cycle after reset deasserts.
